// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer and its pointer controller.
// Latency: n/a (types, constants and a pointer-increment helper only).
// Backpressure: n/a.
package rob_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int ROB_ID_W  = 5;
  localparam int ROB_CNT_W = ROB_ID_W + 1;

  typedef logic [ROB_ID_W-1:0]  rob_id_t;
  typedef logic [ROB_CNT_W-1:0] rob_cnt_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        has_dest;
    logic [4:0]  rd;
    logic [31:0] value;
    logic        mispredict;
    logic [31:0] target;
  } rob_entry_t;

  // Ring increment; explicit wrap keeps it correct if depth and id width ever diverge.
  function automatic rob_id_t rob_id_inc(input rob_id_t id);
    return (id == rob_id_t'(ROB_DEPTH - 1)) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / rename / CDB / commit / flush bundle between the ROB and its neighbours.
// Latency: wiring only. ROB_QUERY_EN adds the two operand-forwarding query channels.
// Backpressure: _rob_full tells the issuer to hold; rdy_in (outside the bundle) freezes everything.
interface reorder_buffer_if;
  import rob_pkg::*;

  logic        _issue_valid;
  logic        _issue_has_dest;
  logic [4:0]  _issue_register_id;

  logic        _rob_full;
  rob_id_t     _rob_tail_id;

  logic        _rob_launch_ready;
  rob_id_t     _rob_launch_rob_id;
  logic [4:0]  _rob_launch_register_id;

  logic        _cdb_ready;
  rob_id_t     _cdb_rob_id;
  logic [31:0] _cdb_value;
  logic        _cdb_mispredict;
  logic [31:0] _cdb_target_pc;

  logic        _rob_commit_ready;
  rob_id_t     _rob_commit_rob_id;
  logic [4:0]  _rob_commit_register_id;
  logic [31:0] _rob_commit_value;

  logic        _rob_flush;
  logic [31:0] _rob_flush_pc;

`ifdef ROB_QUERY_EN
  rob_id_t     _query_rob_id_1;
  rob_id_t     _query_rob_id_2;
  logic        _query_ready_1;
  logic        _query_ready_2;
  logic [31:0] _query_value_1;
  logic [31:0] _query_value_2;
`endif

  // Environment side: fetcher, CDB and register file.
  modport master (
    output _issue_valid, _issue_has_dest, _issue_register_id,
    output _cdb_ready, _cdb_rob_id, _cdb_value, _cdb_mispredict, _cdb_target_pc,
    input  _rob_full, _rob_tail_id,
    input  _rob_launch_ready, _rob_launch_rob_id, _rob_launch_register_id,
    input  _rob_commit_ready, _rob_commit_rob_id, _rob_commit_register_id, _rob_commit_value,
    input  _rob_flush, _rob_flush_pc
`ifdef ROB_QUERY_EN
    , output _query_rob_id_1, _query_rob_id_2,
    input  _query_ready_1, _query_ready_2, _query_value_1, _query_value_2
`endif
  );

  // ROB side.
  modport slave (
    input  _issue_valid, _issue_has_dest, _issue_register_id,
    input  _cdb_ready, _cdb_rob_id, _cdb_value, _cdb_mispredict, _cdb_target_pc,
    output _rob_full, _rob_tail_id,
    output _rob_launch_ready, _rob_launch_rob_id, _rob_launch_register_id,
    output _rob_commit_ready, _rob_commit_rob_id, _rob_commit_register_id, _rob_commit_value,
    output _rob_flush, _rob_flush_pc
`ifdef ROB_QUERY_EN
    , input _query_rob_id_1, _query_rob_id_2,
    output _query_ready_1, _query_ready_2, _query_value_1, _query_value_2
`endif
  );

endinterface

// File: rtl/rob_ptr_ctrl.sv
// Ring bookkeeping for the reorder buffer: head, tail, occupancy and full.
// Latency: pointers move on the edge after push/pop/flush; full decodes the registered count.
// Backpressure: full stops further pushes; push/pop arrive already qualified by rdy_in.
module rob_ptr_ctrl
  import rob_pkg::*;
(
  input  logic    clk_in,
  input  logic    rst_in,
  input  logic    push,
  input  logic    pop,
  input  logic    flush,
  output rob_id_t head,
  output rob_id_t tail,
  output logic    full
);

  rob_id_t  head_q, head_d;
  rob_id_t  tail_q, tail_d;
  rob_cnt_t count_q, count_d;

  // Next pointers and occupancy; a flush empties the ring whatever else happens.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = rob_id_inc(tail_q);
      if (pop)  head_d = rob_id_inc(head_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Pointer state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head = head_q;
  assign tail = tail_q;
  assign full = (count_q == rob_cnt_t'(ROB_DEPTH));

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at issue, absorbs CDB results, commits from head, flushes on mispredict.
// Latency: launch is combinational; commit/flush pulse one cycle after the head retires (>=1 edge after its CDB).
// Backpressure: _rob_full refuses issue; rdy_in low freezes state and suppresses commit. ROB_QUERY_EN adds operand queries.
module reorder_buffer
  import rob_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  reorder_buffer_if.slave  bus
);

  rob_entry_t entry_q [ROB_DEPTH];
  rob_entry_t entry_d [ROB_DEPTH];

  rob_id_t    head, tail;
  logic       full;
  rob_entry_t head_ent;
  logic       commit_fire, flush_now, accept, cdb_wr;

  logic        commit_ready_q, commit_ready_d;
  rob_id_t     commit_rob_id_q, commit_rob_id_d;
  logic [4:0]  commit_reg_q, commit_reg_d;
  logic [31:0] commit_value_q, commit_value_d;
  logic        flush_q, flush_d;
  logic [31:0] flush_pc_q, flush_pc_d;

  assign head_ent    = entry_q[head];
  assign commit_fire = rdy_in & head_ent.busy & head_ent.done;
  // A retiring mispredict squashes everything younger, including this cycle's issue.
  assign flush_now   = commit_fire & head_ent.mispredict;
  assign accept      = bus._issue_valid & ~full & rdy_in & ~flush_now;
  assign cdb_wr      = rdy_in & bus._cdb_ready & entry_q[bus._cdb_rob_id].busy;

  rob_ptr_ctrl u_ptr (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (accept),
    .pop    (commit_fire),
    .flush  (flush_now),
    .head   (head),
    .tail   (tail),
    .full   (full)
  );

  // Entry updates: CDB result, then head retire, then new allocation; flush overrides all busy bits.
  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++) entry_d[i] = entry_q[i];
    if (cdb_wr) begin
      entry_d[bus._cdb_rob_id].done       = 1'b1;
      entry_d[bus._cdb_rob_id].value      = bus._cdb_value;
      entry_d[bus._cdb_rob_id].mispredict = bus._cdb_mispredict;
      entry_d[bus._cdb_rob_id].target     = bus._cdb_target_pc;
    end
    if (commit_fire) entry_d[head].busy = 1'b0;
    if (accept) begin
      entry_d[tail].busy       = 1'b1;
      entry_d[tail].done       = 1'b0;
      entry_d[tail].has_dest   = bus._issue_has_dest;
      entry_d[tail].rd         = bus._issue_register_id;
      entry_d[tail].value      = '0;
      entry_d[tail].mispredict = 1'b0;
      entry_d[tail].target     = '0;
    end
    if (flush_now) begin
      for (int i = 0; i < ROB_DEPTH; i++) entry_d[i].busy = 1'b0;
    end
  end

  // Commit and flush pulses; fields are zeroed when no pulse so idle outputs read 0.
  always_comb begin
    commit_ready_d  = commit_fire & head_ent.has_dest;
    commit_rob_id_d = commit_ready_d ? head : '0;
    commit_reg_d    = commit_ready_d ? head_ent.rd : 5'd0;
    commit_value_d  = commit_ready_d ? head_ent.value : 32'd0;
    flush_d         = flush_now;
    flush_pc_d      = flush_now ? head_ent.target : 32'd0;
  end

  // Entry array and output pulse registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < ROB_DEPTH; i++) entry_q[i] <= '0;
      commit_ready_q  <= 1'b0;
      commit_rob_id_q <= '0;
      commit_reg_q    <= '0;
      commit_value_q  <= '0;
      flush_q         <= 1'b0;
      flush_pc_q      <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) entry_q[i] <= entry_d[i];
      commit_ready_q  <= commit_ready_d;
      commit_rob_id_q <= commit_rob_id_d;
      commit_reg_q    <= commit_reg_d;
      commit_value_q  <= commit_value_d;
      flush_q         <= flush_d;
      flush_pc_q      <= flush_pc_d;
    end
  end

  assign bus._rob_full               = full;
  assign bus._rob_tail_id            = tail;
  assign bus._rob_launch_ready       = accept & bus._issue_has_dest;
  assign bus._rob_launch_rob_id      = tail;
  assign bus._rob_launch_register_id = (accept & bus._issue_has_dest) ? bus._issue_register_id : 5'd0;

  assign bus._rob_commit_ready       = commit_ready_q;
  assign bus._rob_commit_rob_id      = commit_rob_id_q;
  assign bus._rob_commit_register_id = commit_reg_q;
  assign bus._rob_commit_value       = commit_value_q;
  assign bus._rob_flush              = flush_q;
  assign bus._rob_flush_pc           = flush_pc_q;

`ifdef ROB_QUERY_EN
  logic hit_1, hit_2;
  // A same-cycle CDB result for the queried id is forwarded ahead of the stored value.
  assign hit_1 = bus._cdb_ready & (bus._cdb_rob_id == bus._query_rob_id_1);
  assign hit_2 = bus._cdb_ready & (bus._cdb_rob_id == bus._query_rob_id_2);
  assign bus._query_ready_1 = (entry_q[bus._query_rob_id_1].busy & entry_q[bus._query_rob_id_1].done) | hit_1;
  assign bus._query_ready_2 = (entry_q[bus._query_rob_id_2].busy & entry_q[bus._query_rob_id_2].done) | hit_2;
  assign bus._query_value_1 = hit_1 ? bus._cdb_value : entry_q[bus._query_rob_id_1].value;
  assign bus._query_value_2 = hit_2 ? bus._cdb_value : entry_q[bus._query_rob_id_2].value;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table, corner-case sequences, random run vs a queue model.
// Latency: combinational outputs sampled at negedge, registered outputs 1 time unit after posedge.
// Backpressure: exercises full, flush-blocked issue and rdy_in freeze.
module tb_reorder_buffer;
  import rob_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  reorder_buffer_if rob_if ();

  reorder_buffer dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (rob_if)
  );

  always #5 clk_in = ~clk_in;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: program-order queue of live ids plus per-id payload.
  int          m_order[$];
  bit          m_busy[ROB_DEPTH];
  bit          m_done[ROB_DEPTH];
  bit          m_hd[ROB_DEPTH];
  logic [4:0]  m_rd[ROB_DEPTH];
  logic [31:0] m_val[ROB_DEPTH];
  bit          m_mp[ROB_DEPTH];
  logic [31:0] m_tgt[ROB_DEPTH];
  int          m_tail;

  logic        e_cr, e_fl;
  logic [4:0]  e_cid, e_creg;
  logic [31:0] e_cval, e_fpc;

  typedef struct {
    logic        iv;
    logic        hd;
    logic [4:0]  rd;
    logic        cr;
    logic [4:0]  cid;
    logic [31:0] cval;
    logic        lr;
    logic [4:0]  lid;
    logic        cmt;
    logic [4:0]  creg;
    logic [31:0] cv;
    logic [4:0]  tail_after;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rob_if._issue_valid       = 1'b0;
    rob_if._issue_has_dest    = 1'b0;
    rob_if._issue_register_id = 5'd0;
    rob_if._cdb_ready         = 1'b0;
    rob_if._cdb_rob_id        = 5'd0;
    rob_if._cdb_value         = 32'd0;
    rob_if._cdb_mispredict    = 1'b0;
    rob_if._cdb_target_pc     = 32'd0;
`ifdef ROB_QUERY_EN
    rob_if._query_rob_id_1    = 5'd0;
    rob_if._query_rob_id_2    = 5'd0;
`endif
  endtask

  task automatic issue(input logic hd, input logic [4:0] rd);
    idle();
    rob_if._issue_valid       = 1'b1;
    rob_if._issue_has_dest    = hd;
    rob_if._issue_register_id = rd;
  endtask

  task automatic cdb(input logic [4:0] id, input logic [31:0] val, input logic mp, input logic [31:0] tgt);
    idle();
    rob_if._cdb_ready      = 1'b1;
    rob_if._cdb_rob_id     = id;
    rob_if._cdb_value      = val;
    rob_if._cdb_mispredict = mp;
    rob_if._cdb_target_pc  = tgt;
  endtask

  // Negedge half: check combinational outputs, predict registered outputs, advance the model.
  task automatic step_pre();
    int h;
    bit fire, fl, acc;
    @(negedge clk_in);
    h    = (m_order.size() > 0) ? m_order[0] : 0;
    fire = rdy_in && (m_order.size() > 0) && m_done[h];
    fl   = fire && m_mp[h];
    acc  = rob_if._issue_valid && (m_order.size() < ROB_DEPTH) && rdy_in && !fl;
    chk("full", 32'(rob_if._rob_full), 32'(m_order.size() == ROB_DEPTH));
    chk("tail_id", 32'(rob_if._rob_tail_id), 32'(m_tail));
    chk("launch_ready", 32'(rob_if._rob_launch_ready), 32'(acc && rob_if._issue_has_dest));
    chk("launch_rob_id", 32'(rob_if._rob_launch_rob_id), 32'(m_tail));
    chk("launch_reg", 32'(rob_if._rob_launch_register_id),
        (acc && rob_if._issue_has_dest) ? 32'(rob_if._issue_register_id) : 32'd0);
`ifdef ROB_QUERY_EN
    begin
      int q1, q2;
      bit h1, h2, r1, r2;
      q1 = int'(rob_if._query_rob_id_1);
      q2 = int'(rob_if._query_rob_id_2);
      h1 = rob_if._cdb_ready && (int'(rob_if._cdb_rob_id) == q1);
      h2 = rob_if._cdb_ready && (int'(rob_if._cdb_rob_id) == q2);
      r1 = (m_busy[q1] && m_done[q1]) || h1;
      r2 = (m_busy[q2] && m_done[q2]) || h2;
      chk("query_ready_1", 32'(rob_if._query_ready_1), 32'(r1));
      chk("query_ready_2", 32'(rob_if._query_ready_2), 32'(r2));
      if (r1) chk("query_value_1", rob_if._query_value_1, h1 ? rob_if._cdb_value : m_val[q1]);
      if (r2) chk("query_value_2", rob_if._query_value_2, h2 ? rob_if._cdb_value : m_val[q2]);
    end
`endif
    e_cr   = fire && m_hd[h];
    e_cid  = e_cr ? 5'(h) : 5'd0;
    e_creg = e_cr ? m_rd[h] : 5'd0;
    e_cval = e_cr ? m_val[h] : 32'd0;
    e_fl   = fl;
    e_fpc  = fl ? m_tgt[h] : 32'd0;
    if (rdy_in) begin
      if (rob_if._cdb_ready && m_busy[rob_if._cdb_rob_id]) begin
        m_done[rob_if._cdb_rob_id] = 1'b1;
        m_val[rob_if._cdb_rob_id]  = rob_if._cdb_value;
        m_mp[rob_if._cdb_rob_id]   = rob_if._cdb_mispredict;
        m_tgt[rob_if._cdb_rob_id]  = rob_if._cdb_target_pc;
      end
      if (fire) begin
        m_busy[h] = 1'b0;
        void'(m_order.pop_front());
      end
      if (fl) begin
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_order.delete();
        m_tail = 0;
      end else if (acc) begin
        m_busy[m_tail] = 1'b1;
        m_done[m_tail] = 1'b0;
        m_mp[m_tail]   = 1'b0;
        m_hd[m_tail]   = rob_if._issue_has_dest;
        m_rd[m_tail]   = rob_if._issue_register_id;
        m_order.push_back(m_tail);
        m_tail = (m_tail + 1) % ROB_DEPTH;
      end
    end
  endtask

  // Posedge half: registered outputs against the prediction.
  task automatic step_post();
    @(posedge clk_in);
    #1;
    chk("commit_ready", 32'(rob_if._rob_commit_ready), 32'(e_cr));
    chk("commit_rob_id", 32'(rob_if._rob_commit_rob_id), 32'(e_cid));
    chk("commit_reg", 32'(rob_if._rob_commit_register_id), 32'(e_creg));
    chk("commit_value", rob_if._rob_commit_value, e_cval);
    chk("flush", 32'(rob_if._rob_flush), 32'(e_fl));
    chk("flush_pc", rob_if._rob_flush_pc, e_fpc);
  endtask

  task automatic step();
    step_pre();
    step_post();
  endtask

  task automatic do_reset();
    idle();
    rdy_in = 1'b1;
    #2 rst_in = 1'b0;
    #1;
    chk("rst_commit_ready", 32'(rob_if._rob_commit_ready), 32'd0);
    chk("rst_commit_value", rob_if._rob_commit_value, 32'd0);
    chk("rst_flush", 32'(rob_if._rob_flush), 32'd0);
    chk("rst_flush_pc", rob_if._rob_flush_pc, 32'd0);
    chk("rst_tail_id", 32'(rob_if._rob_tail_id), 32'd0);
    chk("rst_full", 32'(rob_if._rob_full), 32'd0);
    chk("rst_launch_ready", 32'(rob_if._rob_launch_ready), 32'd0);
    m_order.delete();
    foreach (m_busy[i]) begin
      m_busy[i] = 1'b0; m_done[i] = 1'b0; m_hd[i] = 1'b0; m_rd[i] = 5'd0;
      m_val[i] = 32'd0; m_mp[i] = 1'b0; m_tgt[i] = 32'd0;
    end
    m_tail = 0;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
  endtask

  initial begin
    #1000000;
    tests_failed++;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  initial begin
    //            iv    hd    rd     cr    cid    cval          lr    lid    cmt   creg   cv            tail
    tbl[0]  = '{1'b1, 1'b1, 5'd5,  1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b0, 5'd0,  32'h0,        5'd1};
    tbl[1]  = '{1'b0, 1'b0, 5'd0,  1'b1, 5'd0, 32'h1234,     1'b0, 5'd1, 1'b0, 5'd0,  32'h0,        5'd1};
    tbl[2]  = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd1, 1'b1, 5'd5,  32'h1234,     5'd1};
    tbl[3]  = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd1, 1'b0, 5'd0,  32'h0,        5'd1};
    tbl[4]  = '{1'b1, 1'b0, 5'd7,  1'b0, 5'd0, 32'h0,        1'b0, 5'd1, 1'b0, 5'd0,  32'h0,        5'd2};
    tbl[5]  = '{1'b0, 1'b0, 5'd0,  1'b1, 5'd1, 32'h55,       1'b0, 5'd2, 1'b0, 5'd0,  32'h0,        5'd2};
    tbl[6]  = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd2, 1'b0, 5'd0,  32'h0,        5'd2};
    tbl[7]  = '{1'b0, 1'b0, 5'd0,  1'b1, 5'd1, 32'h99,       1'b0, 5'd2, 1'b0, 5'd0,  32'h0,        5'd2};
    tbl[8]  = '{1'b1, 1'b1, 5'd31, 1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 1'b0, 5'd0,  32'h0,        5'd3};
    tbl[9]  = '{1'b0, 1'b0, 5'd0,  1'b1, 5'd2, 32'hDEADBEEF, 1'b0, 5'd3, 1'b0, 5'd0,  32'h0,        5'd3};
    tbl[10] = '{1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 1'b1, 5'd31, 32'hDEADBEEF, 5'd3};

    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle();
    #1;
    do_reset();

    // Basic issue / writeback / commit vectors.
    for (int i = 0; i < 11; i++) begin
      idle();
      rob_if._issue_valid       = tbl[i].iv;
      rob_if._issue_has_dest    = tbl[i].hd;
      rob_if._issue_register_id = tbl[i].rd;
      rob_if._cdb_ready         = tbl[i].cr;
      rob_if._cdb_rob_id        = tbl[i].cid;
      rob_if._cdb_value         = tbl[i].cval;
      step_pre();
      chk("vec_launch_ready", 32'(rob_if._rob_launch_ready), 32'(tbl[i].lr));
      chk("vec_launch_id", 32'(rob_if._rob_launch_rob_id), 32'(tbl[i].lid));
      step_post();
      chk("vec_commit_ready", 32'(rob_if._rob_commit_ready), 32'(tbl[i].cmt));
      chk("vec_commit_reg", 32'(rob_if._rob_commit_register_id), 32'(tbl[i].creg));
      chk("vec_commit_value", rob_if._rob_commit_value, tbl[i].cv);
      chk("vec_tail", 32'(rob_if._rob_tail_id), 32'(tbl[i].tail_after));
    end

    // Out-of-order completion, in-order retirement.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 5'(i + 1));
      step();
    end
    cdb(5'd2, 32'h22, 1'b0, 32'h0); step();
    chk("ooo_none_a", 32'(rob_if._rob_commit_ready), 32'd0);
    cdb(5'd0, 32'h20, 1'b0, 32'h0); step();
    chk("ooo_none_b", 32'(rob_if._rob_commit_ready), 32'd0);
    cdb(5'd1, 32'h21, 1'b0, 32'h0); step();
    chk("ooo_c0_id", 32'(rob_if._rob_commit_rob_id), 32'd0);
    chk("ooo_c0_val", rob_if._rob_commit_value, 32'h20);
    idle(); step();
    chk("ooo_c1_id", 32'(rob_if._rob_commit_rob_id), 32'd1);
    chk("ooo_c1_val", rob_if._rob_commit_value, 32'h21);
    idle(); step();
    chk("ooo_c2_id", 32'(rob_if._rob_commit_rob_id), 32'd2);
    chk("ooo_c2_val", rob_if._rob_commit_value, 32'h22);
    idle(); step();
    chk("ooo_idle", 32'(rob_if._rob_commit_ready), 32'd0);

    // Fill to full, reject, commit one, tail wrap.
    do_reset();
    for (int i = 0; i < ROB_DEPTH; i++) begin
      issue(1'b1, 5'(i));
      step();
    end
    issue(1'b1, 5'd3);
    step_pre();
    chk("full_at_32", 32'(rob_if._rob_full), 32'd1);
    chk("tail_wrapped", 32'(rob_if._rob_tail_id), 32'd0);
    chk("reject_33", 32'(rob_if._rob_launch_ready), 32'd0);
    step_post();
    cdb(5'd0, 32'hA0, 1'b0, 32'h0); step();
    issue(1'b1, 5'd9);
    step_pre();
    chk("full_while_commit", 32'(rob_if._rob_full), 32'd1);
    chk("reject_while_commit", 32'(rob_if._rob_launch_ready), 32'd0);
    step_post();
    chk("full_commit_pulse", 32'(rob_if._rob_commit_ready), 32'd1);
    issue(1'b1, 5'd9);
    step_pre();
    chk("full_dropped", 32'(rob_if._rob_full), 32'd0);
    chk("wrap_launch", 32'(rob_if._rob_launch_ready), 32'd1);
    chk("wrap_launch_id", 32'(rob_if._rob_launch_rob_id), 32'd0);
    step_post();

    // Mispredict at id 1 flushes; issue in the flush cycle is dropped.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 5'(i + 1));
      step();
    end
    cdb(5'd0, 32'h10, 1'b0, 32'h0); step();
    cdb(5'd1, 32'h11, 1'b1, 32'h80); step();
    issue(1'b1, 5'd4);
    step_pre();
    chk("flush_blocks_issue", 32'(rob_if._rob_launch_ready), 32'd0);
    step_post();
    chk("flush_pulse", 32'(rob_if._rob_flush), 32'd1);
    chk("flush_pc", rob_if._rob_flush_pc, 32'h80);
    chk("flush_commit", 32'(rob_if._rob_commit_ready), 32'd1);
    idle();
    step_pre();
    chk("flush_tail0", 32'(rob_if._rob_tail_id), 32'd0);
    step_post();
    chk("flush_single", 32'(rob_if._rob_flush), 32'd0);
    cdb(5'd2, 32'h12, 1'b0, 32'h0); step();
    idle(); step();
    chk("flushed_no_commit", 32'(rob_if._rob_commit_ready), 32'd0);

    // rdy_in low freezes a ready head.
    do_reset();
    issue(1'b1, 5'd6); step();
    cdb(5'd0, 32'h77, 1'b0, 32'h0); step();
    idle();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rdy_low_hold", 32'(rob_if._rob_commit_ready), 32'd0);
    end
    rdy_in = 1'b1;
    step();
    chk("rdy_resume", 32'(rob_if._rob_commit_ready), 32'd1);
    chk("rdy_resume_val", rob_if._rob_commit_value, 32'h77);

`ifdef ROB_QUERY_EN
    // Same-cycle CDB forwarding to the query port.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 5'(i + 1));
      step();
    end
    cdb(5'd3, 32'hBEEF, 1'b0, 32'h0);
    rob_if._query_rob_id_1 = 5'd3;
    rob_if._query_rob_id_2 = 5'd2;
    step_pre();
    chk("query_fwd_ready", 32'(rob_if._query_ready_1), 32'd1);
    chk("query_fwd_value", rob_if._query_value_1, 32'hBEEF);
    chk("query_not_ready", 32'(rob_if._query_ready_2), 32'd0);
    step_post();
`endif

    // Random traffic against the model, with a mid-run reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      idle();
      rdy_in = ($urandom_range(0, 9) != 0);
      rob_if._issue_valid       = ($urandom_range(0, 9) < 6);
      rob_if._issue_has_dest    = 1'($urandom);
      rob_if._issue_register_id = 5'($urandom);
      rob_if._cdb_ready         = ($urandom_range(0, 9) < 5);
      if (m_order.size() > 0 && $urandom_range(0, 9) < 8)
        rob_if._cdb_rob_id = 5'(m_order[$urandom_range(0, m_order.size() - 1)]);
      else
        rob_if._cdb_rob_id = 5'($urandom);
      rob_if._cdb_value      = $urandom;
      rob_if._cdb_mispredict = ($urandom_range(0, 15) == 0);
      rob_if._cdb_target_pc  = $urandom;
`ifdef ROB_QUERY_EN
      rob_if._query_rob_id_1 = 5'($urandom);
      rob_if._query_rob_id_2 = rob_if._cdb_rob_id;
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
